// File: rtl/gpu_pkg.sv
// gpu_pkg: shared rectangle descriptor types, sizes and saturating add
package gpu_pkg;
    localparam int RECT_COUNT = 64;
    localparam int RECT_WORDS = 5;
    localparam int LOAD_WORDS = RECT_COUNT * RECT_WORDS;
    localparam int IDX_W = $clog2(RECT_COUNT);
    localparam logic [15:0] DEFAULT_COLOR = 16'h0000;
    typedef enum logic [2:0] {F_X, F_Y, F_W, F_H, F_COLOR} field_e;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;
    typedef struct packed {
        logic [15:0] left, top, right, bottom, color;
    } rect_t;
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
endpackage

// File: rtl/rect_loader_if.sv
// rect_loader_if: descriptor memory read bus (master issues rd_en/addr, slave returns data one cycle later)
interface rect_loader_if #(parameter int ADDR_WIDTH = 13);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_rd_data;
    modport master(output mem_rd_en, mem_addr, input mem_rd_data);
    modport slave(input mem_rd_en, mem_addr, output mem_rd_data);
endinterface

// File: rtl/rect_shadow_bank.sv
// rect_shadow_bank: RECT_COUNT descriptor registers, one indexed field write per cycle, parallel read-out
//   clk, reset_n : clock, async active-low clear
//   we/idx/fld/data : write data into field fld of rect idx
//   rects        : all stored descriptors
module rect_shadow_bank
    import gpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  field_e                  fld,
    input  logic [15:0]             data,
    output rect_t [RECT_COUNT-1:0]  rects
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            rects <= '0;
        else if (we)
            case (fld)
                F_X:     rects[idx].left   <= data;
                F_Y:     rects[idx].top    <= data;
                F_W:     rects[idx].right  <= data;
                F_H:     rects[idx].bottom <= data;
                default: rects[idx].color  <= data;
            endcase
endmodule

// File: rtl/rect_loader.sv
// rect_loader: per-frame burst load of rectangle descriptors into a shadow bank, published to the active bank on commit
//   clk, reset_n          : clock, async active-low reset
//   frame_start, commit   : 1-cycle pulses starting a load / publishing the shadow bank
//   mem                   : memory read bus (master)
//   rect_left..rect_colors: active bank, right/bottom precomputed and saturated
//   busy, load_done, overrun : load status
module rect_loader
    import gpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 13,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic                          commit,
    rect_loader_if.master                 mem,
    output logic [RECT_COUNT-1:0][15:0]   rect_left,
    output logic [RECT_COUNT-1:0][15:0]   rect_top,
    output logic [RECT_COUNT-1:0][15:0]   rect_right,
    output logic [RECT_COUNT-1:0][15:0]   rect_bottom,
    output logic [RECT_COUNT-1:0][15:0]   rect_colors,
    output logic                          busy,
    output logic                          load_done,
    output logic                          overrun
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + ADDR_WIDTH'(LOAD_WORDS - 1);
    state_e                 state, nxt;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   rd_en, rd_vld, pending, done, ovr, take;
    logic [IDX_W-1:0]       idx;
    field_e                 fld;
    logic [15:0]            wdata;
    rect_t [RECT_COUNT-1:0] shadow, active;

    rect_shadow_bank u_shadow (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (rd_vld),
        .idx     (idx),
        .fld     (fld),
        .data    (wdata),
        .rects   (shadow)
    );

    // Width/height words are turned into right/bottom edges using the x/y already stored for this rect.
    always_comb begin
        nxt   = state == IDLE ? (frame_start ? READ : IDLE)
              : state == READ ? (addr == LAST_ADDR ? DRAIN : READ)
              : IDLE;
        take  = commit && pending && state == IDLE;
        wdata = fld == F_W ? sat_add(shadow[idx].left, mem.mem_rd_data)
              : fld == F_H ? sat_add(shadow[idx].top, mem.mem_rd_data)
              : mem.mem_rd_data;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state   <= IDLE;
            addr    <= '0;
            rd_en   <= 1'b0;
            rd_vld  <= 1'b0;
            idx     <= '0;
            fld     <= F_X;
            pending <= 1'b0;
            done    <= 1'b0;
            ovr     <= 1'b0;
            active  <= '0;
        end else begin
            state   <= nxt;
            addr    <= state == READ ? addr + 1'b1 : BASE_ADDR;
            rd_en   <= nxt == READ;
            // Read data lands one cycle after the strobe, so capture trails issue by one.
            rd_vld  <= rd_en;
            done    <= state == DRAIN;
            if (state == IDLE) begin
                idx <= '0;
                fld <= F_X;
            end else if (rd_vld) begin
                fld <= fld == F_COLOR ? F_X : field_e'(fld + 3'd1);
                idx <= fld == F_COLOR ? idx + 1'b1 : idx;
            end
            pending <= (pending && !take) || state == DRAIN;
            ovr     <= ovr || (frame_start && state != IDLE);
            if (take)
                active <= shadow;
        end

    assign mem.mem_rd_en = rd_en;
    assign mem.mem_addr  = addr;
    assign busy          = state != IDLE;
    assign load_done     = done;
    assign overrun       = ovr;

    for (genvar i = 0; i < RECT_COUNT; i++) begin : g_out
        assign rect_left[i]   = active[i].left;
        assign rect_top[i]    = active[i].top;
        assign rect_right[i]  = active[i].right;
        assign rect_bottom[i] = active[i].bottom;
        assign rect_colors[i] = active[i].color;
    end
endmodule

// File: tb/tb_rect_loader.sv
// tb_rect_loader: directed and random frame loads against a transaction-level model of the loader
module tb_rect_loader;
    import gpu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0;
    logic commit = 1'b0;
    logic [RECT_COUNT-1:0][15:0] rect_left, rect_top, rect_right, rect_bottom, rect_colors;
    logic busy, load_done, overrun;

    always #5 clk = ~clk;

    rect_loader_if #(.ADDR_WIDTH(13)) mem ();

    rect_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .commit      (commit),
        .mem         (mem),
        .rect_left   (rect_left),
        .rect_top    (rect_top),
        .rect_right  (rect_right),
        .rect_bottom (rect_bottom),
        .rect_colors (rect_colors),
        .busy        (busy),
        .load_done   (load_done),
        .overrun     (overrun)
    );

    logic [15:0] mem_arr [LOAD_WORDS];

    // 1-cycle latency memory; garbage when not strobed so late/early capture shows up
    always @(posedge clk)
        mem.mem_rd_data <= (mem.mem_rd_en && mem.mem_addr < 13'(LOAD_WORDS))
                           ? mem_arr[int'(mem.mem_addr)] : 16'($urandom);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: a load is a 321-cycle window; the shadow image is the memory contents decoded at completion.
    rect_t m_act [RECT_COUNT];
    rect_t m_shd [RECT_COUNT];
    bit m_busy, m_pend, m_done, m_ovr, m_start;
    int m_t;

    function automatic logic [15:0] sat16(input int s);
        return s > 65535 ? 16'hFFFF : s[15:0];
    endfunction

    function automatic void snap();
        for (int r = 0; r < RECT_COUNT; r++) begin
            m_shd[r].left   = mem_arr[r*RECT_WORDS];
            m_shd[r].top    = mem_arr[r*RECT_WORDS+1];
            m_shd[r].right  = sat16(int'(mem_arr[r*RECT_WORDS]) + int'(mem_arr[r*RECT_WORDS+2]));
            m_shd[r].bottom = sat16(int'(mem_arr[r*RECT_WORDS+1]) + int'(mem_arr[r*RECT_WORDS+3]));
            m_shd[r].color  = mem_arr[r*RECT_WORDS+4];
        end
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_busy = 0; m_pend = 0; m_done = 0; m_ovr = 0; m_t = 0;
            for (int r = 0; r < RECT_COUNT; r++) begin
                m_act[r] = '0;
                m_shd[r] = '0;
            end
        end else begin
            m_start = frame_start && !m_busy;
            if (frame_start && m_busy) m_ovr = 1;
            if (commit && m_pend && !m_busy) begin
                m_act = m_shd;
                m_pend = 0;
            end
            m_done = 0;
            if (m_busy) begin
                m_t++;
                if (m_t == LOAD_WORDS + 1) begin
                    m_busy = 0; m_done = 1; m_pend = 1;
                    snap();
                end
            end
            if (m_start) begin
                m_busy = 1;
                m_t = 0;
            end
        end
    end

    bit exp_rd;
    int bad;

    initial forever begin
        @(negedge clk);
        exp_rd = m_busy && m_t < LOAD_WORDS;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("mem_rd_en", 64'(mem.mem_rd_en), 64'(exp_rd));
        if (exp_rd) chk("mem_addr", 64'(mem.mem_addr), 64'(m_t));
        chk("load_done", 64'(load_done), 64'(m_done));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        bad = -1;
        for (int r = 0; r < RECT_COUNT; r++)
            if (bad < 0 && {rect_left[r], rect_top[r], rect_right[r], rect_bottom[r], rect_colors[r]} !== m_act[r])
                bad = r;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL rects[%0d] got %h/%h/%h/%h/%h expected %h", bad, rect_left[bad], rect_top[bad],
                     rect_right[bad], rect_bottom[bad], rect_colors[bad], m_act[bad]);
        end
    end

    // Pulse frame_start and wait (bounded) for load_done; optional extra frame_start/commit at a given cycle.
    task automatic run_load(input int fs_at, input int cm_at, output int lat, output int reads);
        frame_start = 1'b1;
        lat = 0;
        reads = 0;
        @(negedge clk);
        frame_start = 1'b0;
        while (!load_done && lat < 1000) begin
            if (mem.mem_rd_en) reads++;
            frame_start = lat == fs_at;
            commit = lat == cm_at;
            @(negedge clk);
            lat++;
        end
        frame_start = 1'b0;
        commit = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    int lat, reads;

    initial begin
        for (int i = 0; i < LOAD_WORDS; i++) mem_arr[i] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t1_rects_zero", 64'(|{rect_left, rect_top, rect_right, rect_bottom, rect_colors}), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_rd_en", 64'(mem.mem_rd_en), 64'd0);

        mem_arr[0] = 16'd10; mem_arr[1] = 16'd20; mem_arr[2] = 16'd30; mem_arr[3] = 16'd40; mem_arr[4] = 16'hF800;
        run_load(-1, -1, lat, reads);
        chk("t2_latency", 64'(lat), 64'd321);
        chk("t2_reads", 64'(reads), 64'd320);
        pulse_commit();
        chk("t2_left", 64'(rect_left[0]), 64'd10);
        chk("t2_top", 64'(rect_top[0]), 64'd20);
        chk("t2_right", 64'(rect_right[0]), 64'd40);
        chk("t2_bottom", 64'(rect_bottom[0]), 64'd60);
        chk("t2_color", 64'(rect_colors[0]), 64'hF800);

        mem_arr[25] = 16'hFFF0; mem_arr[27] = 16'h0020;
        run_load(-1, -1, lat, reads);
        pulse_commit();
        chk("t3_right_sat", 64'(rect_right[5]), 64'hFFFF);
        chk("t3_left5", 64'(rect_left[5]), 64'hFFF0);

        mem_arr[4] = 16'h001F;
        run_load(-1, 150, lat, reads);
        chk("t4_midload_commit_ignored", 64'(rect_colors[0]), 64'hF800);
        pulse_commit();
        chk("t4_color", 64'(rect_colors[0]), 64'h001F);
        chk("t4_no_overrun", 64'(overrun), 64'd0);

        mem_arr[0] = 16'd77;
        run_load(-1, -1, lat, reads);
        mem_arr[0] = 16'd88;
        commit = 1'b1;
        run_load(100, -1, lat, reads);
        chk("t5_commit_before_load", 64'(rect_left[0]), 64'd77);
        chk("t5_overrun", 64'(overrun), 64'd1);
        chk("t5_latency", 64'(lat), 64'd321);
        chk("t5_reads", 64'(reads), 64'd320);
        pulse_commit();
        chk("t5_left", 64'(rect_left[0]), 64'd88);

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (50) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rd_en_async", 64'(mem.mem_rd_en), 64'd0);
        chk("t6_busy_async", 64'(busy), 64'd0);
        chk("t6_overrun_async", 64'(overrun), 64'd0);
        chk("t6_colors_clear", 64'(|rect_colors), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_load(-1, -1, lat, reads);
        chk("t6_reload_reads", 64'(reads), 64'd320);
        pulse_commit();
        chk("t6_reload_left", 64'(rect_left[0]), 64'd88);
        chk("t6_reload_color", 64'(rect_colors[0]), 64'h001F);
        chk("t6_reload_sat", 64'(rect_right[5]), 64'hFFFF);

        for (int i = 0; i < LOAD_WORDS; i++)
            mem_arr[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
        for (int c = 0; c < 12000; c++) begin
            frame_start = $urandom_range(0, 349) == 0;
            commit = $urandom_range(0, 24) == 0;
            if (!busy && !frame_start && $urandom_range(0, 49) == 0)
                mem_arr[$urandom_range(0, LOAD_WORDS - 1)] = 16'($urandom);
            @(negedge clk);
        end
        frame_start = 1'b0;
        commit = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
